maze_draw_scheduler: RTL and testbench
======================================

MAZE_DRAW_SCHEDULER -- requirements
Module: maze_draw_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 65535, the per-phase watchdog limit in clock cycles (used only with WATCHDOG_EN).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to redraw the full maze.
REQ-005 SHALL have port move_req  input  1  single-cycle request that the player moved: erase the old sprite, then draw the new one.
REQ-006 SHALL have ports maze_x  input  9, maze_y  input  8, maze_colour  input  3, maze_plot  input  1; these are the maze position-counter pixel outputs.
REQ-007 SHALL have port maze_done  input  1  sticky completion flag from the maze position counter.
REQ-008 SHALL have ports spr_x  input  9, spr_y  input  8, spr_colour  input  3, spr_plot  input  1, spr_done  input  1  (spr_done is a single-cycle pulse); these are the sprite drawer outputs.
REQ-009 SHALL have outputs maze_en  1, maze_clr_n  1 (active-low counter clear), spr_en  1, spr_erase  1.
REQ-010 SHALL have outputs vga_x  9, vga_y  8, vga_colour  3, vga_plot  1, busy  1, err  1.

Function
REQ-011 SHALL implement the FSM states IDLE, M_CLR, M_DRAW, S_ERASE, S_GAP and S_DRAW.
REQ-012 SHALL latch start and move_req into pend_maze and pend_move in any state; a latched flag is cleared when its phase is entered.
REQ-013 IDLE: pend_maze moves to M_CLR; otherwise pend_move moves to S_ERASE; otherwise the FSM stays in IDLE. Maze has priority over move.
REQ-014 M_CLR SHALL last exactly 1 cycle with maze_clr_n=0, maze_en=0, then move to M_DRAW.
REQ-015 M_DRAW SHALL hold maze_en=1 until maze_done=1, then move to S_DRAW.
REQ-016 Leaving M_DRAW SHALL also clear pend_move, because the new sprite is drawn anyway.
REQ-017 S_ERASE SHALL hold spr_en=1 and spr_erase=1 until spr_done, then move to S_GAP.
REQ-018 S_GAP SHALL last 1 cycle with spr_en=0, so the drawer restarts, then move to S_DRAW.
REQ-019 S_DRAW SHALL hold spr_en=1 and spr_erase=0 until spr_done, then return to IDLE.
REQ-020 A pending request SHALL NOT pre-empt a phase; it is serviced from IDLE.
REQ-021 The VGA port SHALL be a registered mux with 1-cycle latency:
- in M_DRAW: vga_* <= maze_*.
- in S_ERASE and S_DRAW: vga_* <= spr_*.
- in all other states: vga_plot <= 0 and x/y/colour hold their values.
REQ-022 vga_plot SHALL never be 1 in the cycle after a state with no owner.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 If start and move_req arrive in the same cycle, the sequence SHALL be M_CLR, M_DRAW, S_DRAW; there is no erase.
REQ-025 A second start during M_DRAW SHALL set pend_maze, causing one further full redraw after S_DRAW.

Reset
REQ-026 While resetn=0 the block SHALL hold:
- state=IDLE;
- pend_maze=0 and pend_move=0;
- maze_en=0, maze_clr_n=0, spr_en=0, spr_erase=0;
- vga_x=0, vga_y=0, vga_colour=0, vga_plot=0;
- busy=0, err=0.
REQ-027 Reset asserted mid-phase SHALL abort immediately with no further vga_plot; after release the FSM SHALL start in IDLE with no pending work.
REQ-028 maze_clr_n SHALL return to 1 on the first clock edge after release.

Configuration
REQ-029 With macro MAZE_SCHED_WATCHDOG_EN defined, a 16-bit counter SHALL clear on each phase entry and increment every cycle in M_DRAW, S_ERASE and S_DRAW.
REQ-030 Under MAZE_SCHED_WATCHDOG_EN, when the counter reaches TIMEOUT the FSM SHALL go to IDLE and set err=1, sticky until reset, with pending flags kept.
REQ-031 Without MAZE_SCHED_WATCHDOG_EN, the block SHALL have no counter, err SHALL be tied to 0, and phases SHALL wait indefinitely.

Verification
REQ-032 Reset release, then a start pulse -> 1 cycle with maze_clr_n=0, then maze_en=1; model maze_done at cycle 100 -> spr_en=1 and spr_erase=0; spr_done -> IDLE and busy=0.
REQ-033 move_req in IDLE -> S_ERASE (spr_erase=1); on spr_done, exactly 1 cycle with spr_en=0; then S_DRAW; vga_plot follows spr_plot delayed by 1 cycle.
REQ-034 start and move_req in the same cycle -> M_CLR, M_DRAW, S_DRAW with no S_ERASE; move_req during M_DRAW -> discarded and no erase.
REQ-035 start pulse during M_DRAW -> after S_DRAW the FSM re-enters M_CLR exactly once.
REQ-036 resetn=0 mid-M_DRAW while maze_plot=1 -> vga_plot=0 and maze_en=0 at once; after release, IDLE with busy=0.
REQ-037 With MAZE_SCHED_WATCHDOG_EN and TIMEOUT=50, maze_done never asserted -> IDLE after 50 cycles in M_DRAW and err=1, held until reset; without the macro, err=0 and the FSM stays in M_DRAW.

Source files
------------

// File: rtl/maze_draw_scheduler.sv
// Sequences maze redraws and sprite erase/redraw passes, and muxes the active drawer onto the VGA port.
// Optional per-phase watchdog enabled by defining MAZE_SCHED_WATCHDOG_EN.
module maze_draw_scheduler #(
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       move_req,
  input  logic [8:0] maze_x,
  input  logic [7:0] maze_y,
  input  logic [2:0] maze_colour,
  input  logic       maze_plot,
  input  logic       maze_done,
  input  logic [8:0] spr_x,
  input  logic [7:0] spr_y,
  input  logic [2:0] spr_colour,
  input  logic       spr_plot,
  input  logic       spr_done,
  output logic       maze_en,
  output logic       maze_clr_n,
  output logic       spr_en,
  output logic       spr_erase,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    M_CLR   = 3'd1,
    M_DRAW  = 3'd2,
    S_ERASE = 3'd3,
    S_GAP   = 3'd4,
    S_DRAW  = 3'd5
  } state_t;

  state_t state, state_next;
  logic   pend_maze, pend_move;
  logic   want_maze, want_move;
  logic   timeout;

  // A request arriving this cycle is treated as already pending.
  assign want_maze = pend_maze | start;
  assign want_move = pend_move | move_req;

  // Next-state decode; completion takes priority over a watchdog expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (want_maze) begin
          state_next = M_CLR;
        end else if (want_move) begin
          state_next = S_ERASE;
        end else begin
          state_next = IDLE;
        end
      end
      M_CLR: state_next = M_DRAW;
      M_DRAW: begin
        if (maze_done) begin
          state_next = S_DRAW;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          state_next = M_DRAW;
        end
      end
      S_ERASE: begin
        if (spr_done) begin
          state_next = S_GAP;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          state_next = S_ERASE;
        end
      end
      S_GAP: state_next = S_DRAW;
      S_DRAW: begin
        if (spr_done || timeout) begin
          state_next = IDLE;
        end else begin
          state_next = S_DRAW;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pending requests and control outputs registered from the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pend_maze  <= 1'b0;
      pend_move  <= 1'b0;
      maze_en    <= 1'b0;
      maze_clr_n <= 1'b0;
      spr_en     <= 1'b0;
      spr_erase  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      pend_maze  <= (state == IDLE && state_next == M_CLR) ? 1'b0 : want_maze;
      // A finished maze redraw always draws the sprite, so a queued move is redundant.
      pend_move  <= ((state == IDLE && state_next == S_ERASE) ||
                     (state == M_DRAW && state_next == S_DRAW)) ? 1'b0 : want_move;
      maze_en    <= (state_next == M_DRAW);
      maze_clr_n <= (state_next != M_CLR);
      spr_en     <= (state_next == S_ERASE) || (state_next == S_DRAW);
      spr_erase  <= (state_next == S_ERASE);
      busy       <= (state_next != IDLE);
    end
  end

  // VGA port mux: the phase owner's pixel appears one cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= 9'd0;
      vga_y      <= 8'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
    end else begin
      case (state)
        M_DRAW: begin
          vga_x      <= maze_x;
          vga_y      <= maze_y;
          vga_colour <= maze_colour;
          vga_plot   <= maze_plot;
        end
        S_ERASE, S_DRAW: begin
          vga_x      <= spr_x;
          vga_y      <= spr_y;
          vga_colour <= spr_colour;
          vga_plot   <= spr_plot;
        end
        default: vga_plot <= 1'b0;
      endcase
    end
  end

`ifdef MAZE_SCHED_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt;
  logic        wd_err;
  logic        counting;
  logic        phase_end;

  assign counting  = (state == M_DRAW) || (state == S_ERASE) || (state == S_DRAW);
  assign phase_end = (state == M_DRAW) ? maze_done : spr_done;
  assign timeout   = counting && (wd_cnt == WD_LAST);
  assign err       = wd_err;

  // Phase watchdog; zero on every phase entry, error flag sticky until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= 16'd0;
      wd_err <= 1'b0;
    end else begin
      if (counting && !phase_end && !timeout) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else begin
        wd_cnt <= 16'd0;
      end
      wd_err <= wd_err | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_maze_draw_scheduler.sv
// Directed, table-driven bench for maze_draw_scheduler plus reset and watchdog sequences.
module tb_maze_draw_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, move_req;
  logic [8:0] maze_x, spr_x;
  logic [7:0] maze_y, spr_y;
  logic [2:0] maze_colour, spr_colour;
  logic       maze_plot, maze_done, spr_plot, spr_done;
  logic       maze_en, maze_clr_n, spr_en, spr_erase;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, err;

  int tests = 0;
  int fails = 0;

  maze_draw_scheduler #(.TIMEOUT(50)) dut (
    .clk(clk), .resetn(resetn), .start(start), .move_req(move_req),
    .maze_x(maze_x), .maze_y(maze_y), .maze_colour(maze_colour),
    .maze_plot(maze_plot), .maze_done(maze_done),
    .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour),
    .spr_plot(spr_plot), .spr_done(spr_done),
    .maze_en(maze_en), .maze_clr_n(maze_clr_n), .spr_en(spr_en), .spr_erase(spr_erase),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // in  = {start, move_req, maze_done, spr_done, maze_plot, spr_plot}
  // exp = {maze_en, maze_clr_n, spr_en, spr_erase, busy, vga_plot}
  typedef struct packed {
    logic [5:0] in;
    logic [5:0] exp;
    logic [8:0] x;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t v(input logic [5:0] in, input logic [5:0] exp, input logic [8:0] x);
    vec_t r;
    r.in  = in;
    r.exp = exp;
    r.x   = x;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] in);
    {start, move_req, maze_done, spr_done, maze_plot, spr_plot} = in;
  endtask

  function automatic logic [14:0] outs();
    return {maze_en, maze_clr_n, spr_en, spr_erase, busy, vga_plot, vga_x};
  endfunction

  initial begin
    resetn = 1'b0;
    drive(6'b000000);
    maze_x = 9'd100; maze_y = 8'd50; maze_colour = 3'd5;
    spr_x  = 9'd7;   spr_y  = 8'd9;  spr_colour  = 3'd2;

    vecs[0]  = v(6'b000000, 6'b010000, 9'd0);
    vecs[1]  = v(6'b100000, 6'b000010, 9'd0);
    vecs[2]  = v(6'b000010, 6'b110010, 9'd0);
    vecs[3]  = v(6'b000010, 6'b110011, 9'd100);
    vecs[4]  = v(6'b010000, 6'b110010, 9'd100);
    vecs[5]  = v(6'b001010, 6'b011011, 9'd100);
    vecs[6]  = v(6'b000001, 6'b011011, 9'd7);
    vecs[7]  = v(6'b000100, 6'b010000, 9'd7);
    vecs[8]  = v(6'b000000, 6'b010000, 9'd7);
    vecs[9]  = v(6'b010000, 6'b011110, 9'd7);
    vecs[10] = v(6'b000001, 6'b011111, 9'd7);
    vecs[11] = v(6'b000101, 6'b010011, 9'd7);
    vecs[12] = v(6'b000001, 6'b011010, 9'd7);
    vecs[13] = v(6'b000000, 6'b011010, 9'd7);
    vecs[14] = v(6'b000100, 6'b010000, 9'd7);
    vecs[15] = v(6'b110000, 6'b000010, 9'd7);
    vecs[16] = v(6'b000000, 6'b110010, 9'd7);
    vecs[17] = v(6'b100000, 6'b110010, 9'd100);
    vecs[18] = v(6'b001000, 6'b011010, 9'd100);
    vecs[19] = v(6'b000100, 6'b010000, 9'd7);
    vecs[20] = v(6'b000000, 6'b000010, 9'd7);
    vecs[21] = v(6'b000000, 6'b110010, 9'd7);
    vecs[22] = v(6'b001000, 6'b011010, 9'd100);
    vecs[23] = v(6'b000100, 6'b010000, 9'd7);
    vecs[24] = v(6'b000000, 6'b010000, 9'd7);
    vecs[25] = v(6'b000000, 6'b010000, 9'd7);

    // Values held during reset.
    #3;
    check("reset_outs", {17'd0, outs()}, 32'd0);
    check("reset_vga_err", {20'd0, vga_y, vga_colour, err}, 32'd0);
    #9 resetn = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].in);
      step();
      check($sformatf("row%0d", i), {17'd0, outs()}, {17'd0, vecs[i].exp, vecs[i].x});
    end

    // Reset asserted mid maze draw with a plot in flight and a move queued.
    drive(6'b100000); step();
    drive(6'b010010); step();
    drive(6'b000010); step();
    check("mid_plot", {19'd0, vga_plot, vga_y, vga_colour}, {19'd0, 1'b1, 8'd50, 3'd5});
    #2 resetn = 1'b0;
    #1;
    check("async_abort", {26'd0, vga_plot, maze_en, busy, maze_clr_n, spr_en, err}, 32'd0);
    #2 resetn = 1'b1;
    drive(6'b000000);
    step();
    check("post_reset", {27'd0, maze_clr_n, busy, maze_en, spr_en, vga_plot}, {27'd0, 5'b10000});
    step(); step();
    check("post_reset_idle", {29'd0, busy, spr_en, spr_erase}, 32'd0);

    // Maze phase with maze_done never arriving.
    drive(6'b100000); step();
    drive(6'b000000); step();
    repeat (40) step();
    check("long_draw_40", {30'd0, maze_en, busy}, {30'd0, 2'b11});
    repeat (20) step();
`ifdef MAZE_SCHED_WATCHDOG_EN
    check("wd_timeout", {29'd0, busy, maze_en, err}, {29'd0, 3'b001});
    repeat (5) step();
    check("wd_err_sticky", {30'd0, err, busy}, {30'd0, 2'b10});
    resetn = 1'b0;
    #1;
    check("wd_err_reset", {31'd0, err}, 32'd0);
    #2 resetn = 1'b1;
    step();
`else
    check("no_wd_wait", {29'd0, busy, maze_en, err}, {29'd0, 3'b110});
    drive(6'b001000); step();
    check("late_done", {29'd0, spr_en, spr_erase, maze_en}, {29'd0, 3'b100});
    drive(6'b000100); step();
    drive(6'b000000);
    check("late_idle", {30'd0, busy, err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
